seg_message_scroller: RTL and testbench

SEG_MESSAGE_SCROLLER -- requirements
Module: seg_message_scroller

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_tick_gen.sv | 29 ++
 rtl/seg_message_scroller.sv | 148 ++++++++++++++
 tb/tb_seg_message_scroller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared character constants and state type for the message scroller
package seg_pkg;

  localparam int CHAR_W = 5;

  localparam logic [CHAR_W-1:0] SEG_BLANK  = 5'd31;
  localparam logic [CHAR_W-1:0] SEG_HYPHEN = 5'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    DONE   = 2'd3
  } seg_state_t;

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - scroll-step prescaler, one-cycle step every CLK_DIV cycles
module seg_tick_gen #(
  parameter int CLK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic step
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign step = (count == LAST);

  // Count 0..CLK_DIV-1; clear holds the count at zero so a new pass starts aligned
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (step) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seg_message_scroller.sv
// rtl/seg_message_scroller.sv - buffers a message and scrolls it across four digits (option: SEG_SCROLL_STATIC_EN)
module seg_message_scroller
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 25000000,
  parameter int MSG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [4:0]  char_data,
  input  logic        char_last,
  input  logic        loop_en,
  input  logic        abort,
  output logic        msg_done,
  output logic [19:0] seg_data
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

  seg_state_t state, state_next;

  logic [CHAR_W-1:0] msg_buf [MSG_DEPTH];
  logic [4:0]        wr_ptr;
  logic [4:0]        len;
  logic [4:0]        pos;
  logic              xfer;
  logic              load_done;
  logic              step;
  logic              at_end;
  logic              static_mode;
  logic [5:0]        base;
  logic [5:0]        idx;
  logic [19:0]       window;

  // An aborted cycle never counts as a transfer, even though char_ready is high
  assign xfer      = char_valid && char_ready && !abort;
  assign load_done = xfer && (char_last || (wr_ptr == 5'(MSG_DEPTH - 1)));
  assign at_end    = ({1'b0, pos} == ({1'b0, len} + 6'd4));

  seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear ((state != SCROLL) || abort),
    .step  (step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every other event
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (load_done) state_next = SCROLL;
          else if (xfer) state_next = LOAD;
        end
        SCROLL: begin
          if (step && !static_mode && at_end && !loop_en) state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake and completion outputs decoded from state
  always_comb begin
    char_ready = (state == IDLE) || (state == LOAD);
    msg_done   = (state == DONE);
  end

  // Character storage; contents need no reset
  always_ff @(posedge clk) begin
    if (xfer) msg_buf[AW'(wr_ptr)] <= char_data;
  end

  // Write pointer, message length and scroll position
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      len    <= '0;
      pos    <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      pos    <= '0;
    end else begin
      if (load_done) begin
        len    <= wr_ptr + 5'd1;
        wr_ptr <= '0;
        pos    <= '0;
      end else if (xfer) begin
        wr_ptr <= wr_ptr + 5'd1;
      end
      if (state == SCROLL && step && !static_mode) begin
        pos <= at_end ? 5'd0 : pos + 5'd1;
      end
    end
  end

`ifdef SEG_SCROLL_STATIC_EN
  // Short messages are frozen left-justified until abort or reset
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      static_mode <= 1'b0;
    end else if (load_done) begin
      static_mode <= (wr_ptr < 5'd4);
    end
  end
`else
  assign static_mode = 1'b0;
`endif

  // Four-digit window into the virtual stream: blanks, message, blanks
  always_comb begin
    window = '1;
    idx    = '0;
    base   = static_mode ? 6'd4 : {1'b0, pos};
    if (state == SCROLL) begin
      for (int k = 0; k < 4; k++) begin
        idx = base + 6'(k);
        if (idx >= 6'd4 && idx < ({1'b0, len} + 6'd4)) begin
          window[(3 - k) * 5 +: 5] = msg_buf[AW'(idx - 6'd4)];
        end
      end
    end
  end

  // Registered display output, one cycle behind state and pos
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_data <= 20'hFFFFF;
    end else begin
      seg_data <= window;
    end
  end

endmodule

// File: tb/tb_seg_message_scroller.sv
// tb/tb_seg_message_scroller.sv - randomized self-checking bench for seg_message_scroller
module tb_seg_message_scroller;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_valid;
  logic        char_ready;
  logic [4:0]  char_data;
  logic        char_last;
  logic        loop_en;
  logic        abort;
  logic        msg_done;
  logic [19:0] seg_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int msg[$];

  seg_message_scroller #(.CLK_DIV(CLK_DIV), .MSG_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_last  (char_last),
    .loop_en    (loop_en),
    .abort      (abort),
    .msg_done   (msg_done),
    .seg_data   (seg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout n_total=%0d", n_total);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Digit shown for virtual stream position i
  function automatic int stream_at(int i);
    if (i >= 4 && i < 4 + msg.size()) return msg[i - 4];
    return 31;
  endfunction

  // Scrolling window starting at stream position p, leftmost digit first
  function automatic logic [19:0] exp_window(int p);
    logic [19:0] w;
    int d;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      d = stream_at(p + k);
      w = {w[14:0], d[4:0]};
    end
    return w;
  endfunction

  // Static left-justified view of a short message
  function automatic logic [19:0] exp_static();
    logic [19:0] w;
    int d;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      d = (k < msg.size()) ? msg[k] : 31;
      w = {w[14:0], d[4:0]};
    end
    return w;
  endfunction

  function automatic void fill_random(int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(int'($urandom_range(0, 31)));
  endfunction

  // Offer every character of msg; last_flag marks the final one
  task automatic load_msg(input bit last_flag);
    for (int i = 0; i < msg.size(); i++) begin
      char_valid = 1'b1;
      char_data  = 5'(msg[i]);
      char_last  = last_flag && (i == msg.size() - 1);
      check("ready_load", 20'(char_ready), 20'd1);
      tick();
    end
    char_valid = 1'b0;
    char_last  = 1'b0;
  endtask

  // One full pass after loading; noise on char_valid must be ignored while scrolling
  task automatic run_once(input string tag);
    int total;
    total = CLK_DIV * (msg.size() + 5);
    for (int c = 0; c <= total + 1; c++) begin
      check({tag, "_seg"}, seg_data, (c == 0 || c > total) ? 20'hFFFFF : exp_window((c - 1) / CLK_DIV));
      check({tag, "_done"}, 20'(msg_done), 20'(c == total));
      check({tag, "_ready"}, 20'(char_ready), 20'(c > total));
      if (c < total) begin
        char_valid = 1'($urandom_range(0, 1));
        char_data  = 5'($urandom_range(0, 31));
        char_last  = 1'($urandom_range(0, 1));
      end else begin
        char_valid = 1'b0;
        char_last  = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    int n;
    int min_len;
    bit lf;
    int period;

`ifdef SEG_SCROLL_STATIC_EN
    min_len = 5;
`else
    min_len = 1;
`endif

    reset = 1'b1; char_valid = 1'b0; char_data = '0; char_last = 1'b0;
    loop_en = 1'b0; abort = 1'b0;
    tick();
    tick();
    check("rst_seg", seg_data, 20'hFFFFF);
    check("rst_ready", 20'(char_ready), 20'd1);
    check("rst_done", 20'(msg_done), 20'd0);
    reset = 1'b0;
    tick();

`ifndef SEG_SCROLL_STATIC_EN
    msg.delete();
    msg.push_back(1); msg.push_back(2); msg.push_back(3);
    load_msg(1'b1);
    run_once("dir123");
`endif

    msg.delete();
    for (int i = 0; i < DEPTH; i++) msg.push_back(int'($urandom_range(0, 31)));
    load_msg(1'b0);
    run_once("full16");

    for (int t = 0; t < 6; t++) begin
      n  = int'($urandom_range(min_len, DEPTH));
      lf = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      fill_random(n);
      load_msg(lf);
      run_once("rand");
    end

    fill_random((min_len > 3) ? min_len : 3);
    load_msg(1'b1);
    for (int c = 0; c < 3 * CLK_DIV; c++) begin
      check("abort_pre_seg", seg_data, (c == 0) ? 20'hFFFFF : exp_window((c - 1) / CLK_DIV));
      tick();
    end
    abort = 1'b1; char_valid = 1'b1; char_last = 1'b1;
    tick();
    abort = 1'b0; char_valid = 1'b0; char_last = 1'b0;
    check("abort_ready", 20'(char_ready), 20'd1);
    check("abort_done", 20'(msg_done), 20'd0);
    tick();
    check("abort_seg", seg_data, 20'hFFFFF);
    check("abort_done2", 20'(msg_done), 20'd0);

    abort = 1'b1; char_valid = 1'b1; char_data = 5'd7; char_last = 1'b1;
    tick();
    abort = 1'b0; char_valid = 1'b0; char_last = 1'b0;
    check("idle_abort_ready", 20'(char_ready), 20'd1);
    tick();
    tick();
    check("idle_abort_ready2", 20'(char_ready), 20'd1);
    check("idle_abort_seg", seg_data, 20'hFFFFF);

    loop_en = 1'b1;
    fill_random((min_len > 2) ? min_len : 2);
    load_msg(1'b1);
    period = msg.size() + 5;
    for (int c = 0; c <= 3 * period * CLK_DIV; c++) begin
      check("loop_seg", seg_data, (c == 0) ? 20'hFFFFF : exp_window(((c - 1) / CLK_DIV) % period));
      check("loop_done", 20'(msg_done), 20'd0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; loop_en = 1'b0;
    check("loop_abort_ready", 20'(char_ready), 20'd1);
    tick();

`ifdef SEG_SCROLL_STATIC_EN
    msg.delete();
    msg.push_back(11); msg.push_back(12);
    load_msg(1'b1);
    tick();
    for (int s = 0; s <= 100; s++) begin
      check("static_seg", seg_data, exp_static());
      check("static_done", 20'(msg_done), 20'd0);
      for (int c = 0; c < CLK_DIV; c++) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("static_abort_ready", 20'(char_ready), 20'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
